weight_loader: RTL and testbench
================================

// Module: weight_loader
// PURPOSE
//  Upstream feeder for the weight BRAM: accepts a narrow valid/ready word stream (host/DMA side),
//  packs WORDS_PER_ROW consecutive words into one DATA_WIDTH-bit row and drives the BRAM
//  write port, one row per write, at consecutive addresses from a programmed base.
//  A start/done control pair frames each load job; the NPU core is released once done pulses.
// PARAMETERS
//  DATA_WIDTH  384  BRAM row width (48 x int8); must be an integer multiple of IN_WIDTH
//  IN_WIDTH    32   input stream word width
//  DEPTH       10   BRAM rows
//  ADDR_WIDTH  4    BRAM address width, clog2(DEPTH)
//  (local) WORDS_PER_ROW = DATA_WIDTH/IN_WIDTH = 12 at defaults
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             async active-low reset
//  start      in   1             1-cycle job request, sampled only in IDLE
//  base_addr  in   ADDR_WIDTH    first row address, sampled with start
//  num_rows   in   ADDR_WIDTH+1  rows in job, sampled with start
//  abort      in   1             sync job cancel
//  s_valid    in   1             input word valid
//  s_ready    out  1             loader can accept a word
//  s_data     in   IN_WIDTH      input word
//  w_en       out  1             BRAM write enable
//  w_addr     out  ADDR_WIDTH    BRAM write address
//  w_data     out  DATA_WIDTH    BRAM write row
//  busy       out  1             state != IDLE
//  done       out  1             1-cycle pulse: last row written
//  err        out  1             1-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; s_ready, w_en, busy, done, err = 0; w_addr, w_data,
//   word counter, row counter, pack register = 0. Reset mid-job discards the partial row, no done.
//  States: IDLE -> LOAD -> DONE -> IDLE.
//  IDLE: s_ready=0. On start: if num_rows==0 or base_addr+num_rows > DEPTH (compute at
//   ADDR_WIDTH+2 bits, no wrap) -> err=1 next cycle, stay IDLE, no writes; else latch
//   base_addr/num_rows, clear counters, go LOAD.
//  LOAD: s_ready=1. Handshake = s_valid & s_ready. Word k (0..WORDS_PER_ROW-1) of a row
//   lands in pack bits [k*IN_WIDTH +: IN_WIDTH] (first word = LSBs).
//   On handshake of word WORDS_PER_ROW-1: next cycle w_en=1, w_data=full packed row,
//   w_addr=base+row_idx; row_idx++, word counter wraps to 0. w_en, w_addr, w_data are registered.
//   Full throughput: s_ready stays 1 during a row write; the next row's word 0 is accepted
//   in the same cycle as the previous row's w_en.
//   If the completed row is row num_rows-1, go DONE instead of staying LOAD.
//  DONE (exactly one cycle): done=1, w_en=1 (final row), s_ready=0, busy=1; then IDLE.
//  w_en is high for exactly one cycle per row; w_addr never exceeds DEPTH-1.
//  start while busy: ignored (no err, no relatch).
//  abort (LOAD or DONE): next cycle IDLE; partial row dropped, no write for it, no done;
//   a row whose w_en is already registered still completes. abort in IDLE: no effect.
//   abort together with start in IDLE: abort wins, job not started.
//  s_valid low in LOAD: counters hold; gaps of any length allowed, no timeout.
//  s_data is don't-care when s_valid=0 or s_ready=0.
// TESTING
//  1 base=0,num=1, 12 back-to-back words 0x00..0x0B -> single w_en at addr 0,
//    w_data word k = k; done in same cycle; busy drops next cycle.
//  2 base=2,num=3, 36 continuous words -> w_en at addrs 2,3,4 exactly 12 cycles apart,
//    s_ready never drops during LOAD, done with addr-4 write.
//  3 num=2 with random s_valid gaps (~50%) -> same w_data/w_addr as gap-free run;
//    exactly 2 w_en pulses.
//  4 start num=0; start base=8,num=3 (DEPTH=10) -> err pulse each, no w_en, busy stays 0;
//    base=7,num=3 accepted.
//  5 num=2, abort after word 17 -> row 0 written at base, no second write, no done,
//    IDLE next cycle; new job then loads cleanly from word 0.
//  6 rst_n low mid-row (word 5 of row 1) -> all outputs 0 immediately;
//    after release, new job writes correct rows with no stale words.

Source files
------------

// File: rtl/weight_loader_if.sv
`default_nettype none
// ============================================================================
// weight_loader_if : input word stream plus BRAM row write port of the loader
// Rev 1.0
// ============================================================================
interface weight_loader_if #(
   parameter int DATA_WIDTH = 384,
   parameter int IN_WIDTH   = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  s_valid;
   logic                  s_ready;
   logic [IN_WIDTH-1:0]   s_data;
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;

   // slave = the loader; master = the host/DMA side and BRAM observer
   modport slave  (input  s_valid, s_data, output s_ready, w_en, w_addr, w_data);
   modport master (output s_valid, s_data, input  s_ready, w_en, w_addr, w_data);
endinterface
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// weight_loader : packs WORDS_PER_ROW stream words into one BRAM row and writes
// rows at consecutive addresses from a programmed base, framed by start/done.
// Rev 1.0
// ============================================================================
module weight_loader #(
   parameter int DATA_WIDTH = 384,
   parameter int IN_WIDTH   = 32,
   parameter int DEPTH      = 10,
   parameter int ADDR_WIDTH = 4
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  start_i,
   input  wire logic [ADDR_WIDTH-1:0] base_addr_i,
   input  wire logic [ADDR_WIDTH:0]   num_rows_i,
   input  wire logic                  abort_i,
   weight_loader_if.slave             bus,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   localparam int WORDS_PER_ROW = DATA_WIDTH / IN_WIDTH;
   localparam int WCW           = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

   localparam logic [WCW-1:0]        C_LAST_WORD = WCW'(WORDS_PER_ROW - 1);
   localparam logic [ADDR_WIDTH+1:0] C_DEPTH     = (ADDR_WIDTH + 2)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   C_ONE_ROW   = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WCW-1:0]        word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH:0]   row_cnt_q, row_cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   num_q, num_d;
   logic [DATA_WIDTH-1:0] pack_q, pack_d;
   logic                  w_en_q, w_en_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                  err_q, err_d;

   logic                  w_hs;
   logic [ADDR_WIDTH+1:0] w_job_end;
   logic                  w_job_bad;
   logic [ADDR_WIDTH:0]   w_row_next;

   // Range check is done two bits wider than the address so base+num cannot wrap.
   assign w_job_end  = {2'b00, base_addr_i} + {1'b0, num_rows_i};
   assign w_job_bad  = (num_rows_i == '0) || (w_job_end > C_DEPTH);
   assign w_row_next = row_cnt_q + C_ONE_ROW;

   assign bus.s_ready = (state_q == ST_LOAD);
   assign w_hs        = bus.s_valid && bus.s_ready;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      row_cnt_d  = row_cnt_q;
      base_d     = base_q;
      num_d      = num_q;
      pack_d     = pack_q;
      w_en_d     = 1'b0;
      w_addr_d   = w_addr_q;
      w_data_d   = w_data_q;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               if (w_job_bad) begin
                  err_d = 1'b1;
               end else begin
                  base_d     = base_addr_i;
                  num_d      = num_rows_i;
                  word_cnt_d = '0;
                  row_cnt_d  = '0;
                  state_d    = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (w_hs) begin
               for (int k = 0; k < WORDS_PER_ROW; k++) begin
                  if (word_cnt_q == WCW'(k)) begin
                     pack_d[k*IN_WIDTH +: IN_WIDTH] = bus.s_data;
                  end
               end
               if (word_cnt_q == C_LAST_WORD) begin
                  // The row leaves straight from the merged pack so the next
                  // row's word 0 can be accepted in the same cycle as this write.
                  word_cnt_d = '0;
                  row_cnt_d  = w_row_next;
                  w_en_d     = 1'b1;
                  w_addr_d   = base_q + row_cnt_q[ADDR_WIDTH-1:0];
                  w_data_d   = pack_d;
                  if (w_row_next == num_q) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + WCW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         row_cnt_q  <= '0;
         base_q     <= '0;
         num_q      <= '0;
         pack_q     <= '0;
         w_en_q     <= 1'b0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         row_cnt_q  <= row_cnt_d;
         base_q     <= base_d;
         num_q      <= num_d;
         pack_q     <= pack_d;
         w_en_q     <= w_en_d;
         w_addr_q   <= w_addr_d;
         w_data_q   <= w_data_d;
         err_q      <= err_d;
      end
   end

   assign bus.w_en   = w_en_q;
   assign bus.w_addr = w_addr_q;
   assign bus.w_data = w_data_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// tb_weight_loader : table-driven job vectors plus a mid-row reset sequence.
// Rev 1.0
// ============================================================================
module tb_weight_loader;

   localparam int DW  = 384;
   localparam int IW  = 32;
   localparam int DEP = 10;
   localparam int AW  = 4;
   localparam int WPR = DW / IW;

   typedef struct {
      int base;
      int num;
      int gaps;
      int abort_at;     // words accepted before abort is raised, -1 = none
      int abort_start;  // abort raised together with start
      int restart_at;   // pulse a second start after this many words, -1 = none
      int exp_err;
      int exp_wr;
      int exp_done;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   num_rows_i;
   logic          abort_i;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   weight_loader_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

   weight_loader #(
      .DATA_WIDTH(DW), .IN_WIDTH(IW), .DEPTH(DEP), .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .base_addr_i(base_addr_i),
      .num_rows_i (num_rows_i),
      .abort_i    (abort_i),
      .bus        (bus),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   int            cyc = 0;
   int            wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];
   int            wr_cyc_q[$];
   int            done_cnt, done_nowr, err_cnt, busy_cnt, busy_late, ready_drop;
   logic          prev_done = 1'b0;

   vec_t vecs[13];

   always @(negedge clk) begin
      cyc++;
      if (bus.w_en) begin
         wr_addr_q.push_back(int'(bus.w_addr));
         wr_data_q.push_back(bus.w_data);
         wr_cyc_q.push_back(cyc);
      end
      if (done_o) begin
         done_cnt++;
         if (!bus.w_en) done_nowr++;
      end
      if (err_o) err_cnt++;
      if (busy_o) busy_cnt++;
      if (prev_done && busy_o) busy_late++;
      if (busy_o && !done_o && !bus.s_ready) ready_drop++;
      prev_done = done_o;
   end

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] word(input int vid, input int r, input int k);
      return {8'(vid), 8'(r), 16'(k)};
   endfunction

   function automatic logic [DW-1:0] row_model(input int vid, input int r);
      logic [DW-1:0] row;
      row = '0;
      for (int k = 0; k < WPR; k++) row[k*IW +: IW] = word(vid, r, k);
      return row;
   endfunction

   task automatic run_job(input int vid, input vec_t v);
      int total, idx, guard;
      @(negedge clk);
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      done_cnt = 0; done_nowr = 0; err_cnt = 0; busy_cnt = 0; busy_late = 0; ready_drop = 0;
      base_addr_i = AW'(v.base);
      num_rows_i  = (AW + 1)'(v.num);
      start_i     = 1'b1;
      abort_i     = (v.abort_start != 0);
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      total = v.num * WPR;
      idx   = 0;
      guard = 0;
      if (v.exp_err == 0 && v.abort_start == 0) begin
         while (idx < total && guard < 4000) begin
            if (v.abort_at >= 0 && idx == v.abort_at) break;
            bus.s_valid = (v.gaps != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = bus.s_valid ? word(vid, idx / WPR, idx % WPR) : 32'hDEAD_BEEF;
            if (idx == v.restart_at) begin
               start_i     = 1'b1;
               base_addr_i = '0;
               num_rows_i  = (AW + 1)'(1);
            end
            if (bus.s_valid && bus.s_ready) idx++;
            @(negedge clk);
            start_i = 1'b0;
            guard++;
         end
         bus.s_valid = 1'b0;
         if (v.abort_at >= 0) begin
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
            check_int($sformatf("v%0d_abort_idle", vid), int'(busy_o), 0);
         end else begin
            check_int($sformatf("v%0d_words_fed", vid), idx, total);
         end
      end
      guard = 0;
      while (busy_o && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check_int($sformatf("v%0d_busy_released", vid), int'(busy_o), 0);
      repeat (2) @(negedge clk);

      check_int($sformatf("v%0d_err", vid), err_cnt, v.exp_err);
      check_int($sformatf("v%0d_writes", vid), wr_addr_q.size(), v.exp_wr);
      check_int($sformatf("v%0d_done", vid), done_cnt, v.exp_done);
      check_int($sformatf("v%0d_done_wo_wen", vid), done_nowr, 0);
      check_int($sformatf("v%0d_busy_after_done", vid), busy_late, 0);
      check_int($sformatf("v%0d_ready_drop", vid), ready_drop, 0);
      if (v.exp_err != 0 || v.abort_start != 0)
         check_int($sformatf("v%0d_never_busy", vid), busy_cnt, 0);
      for (int r = 0; r < wr_addr_q.size() && r < v.exp_wr; r++) begin
         check_int($sformatf("v%0d_addr%0d", vid, r), wr_addr_q[r], v.base + r);
         check_vec($sformatf("v%0d_data%0d", vid, r), wr_data_q[r], row_model(vid, r));
         if (r > 0 && v.gaps == 0)
            check_int($sformatf("v%0d_spacing%0d", vid, r), wr_cyc_q[r] - wr_cyc_q[r-1], WPR);
      end
   endtask

   initial begin
      vec_t vr;
      int   idx, guard;
      rst_n       = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      base_addr_i = '0;
      num_rows_i  = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      //          base num gaps abrt abSt rest err wr done
      vecs[0]  = '{0,  1,  0,  -1,  0,  -1,  0,  1,  1};
      vecs[1]  = '{2,  3,  0,  -1,  0,  -1,  0,  3,  1};
      vecs[2]  = '{5,  2,  1,  -1,  0,  -1,  0,  2,  1};
      vecs[3]  = '{0,  0,  0,  -1,  0,  -1,  1,  0,  0};
      vecs[4]  = '{8,  3,  0,  -1,  0,  -1,  1,  0,  0};
      vecs[5]  = '{7,  3,  0,  -1,  0,  -1,  0,  3,  1};
      vecs[6]  = '{0,  2,  0,  18,  0,  -1,  0,  1,  0};
      vecs[7]  = '{3,  1,  0,  -1,  0,  -1,  0,  1,  1};
      vecs[8]  = '{1,  1,  0,  -1,  1,  -1,  0,  0,  0};
      vecs[9]  = '{9,  1,  0,  -1,  0,  -1,  0,  1,  1};
      vecs[10] = '{0, 11,  0,  -1,  0,  -1,  1,  0,  0};
      vecs[11] = '{4,  2,  0,  -1,  0,   5,  0,  2,  1};
      vecs[12] = '{0, 10,  0,  -1,  0,  -1,  0, 10,  1};

      repeat (3) @(negedge clk);
      check_int("reset_ctl", int'({bus.w_en, bus.s_ready, busy_o, done_o, err_o}), 0);
      check_int("reset_addr", int'(bus.w_addr), 0);
      check_vec("reset_wdata", bus.w_data, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_job(i, vecs[i]);

      // Reset lands after word 5 of row 1; the following job must see no stale words.
      @(negedge clk);
      base_addr_i = AW'(1);
      num_rows_i  = (AW + 1)'(3);
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      idx     = 0;
      guard   = 0;
      while (idx < WPR + 5 && guard < 200) begin
         bus.s_valid = 1'b1;
         bus.s_data  = word(30, idx / WPR, idx % WPR);
         if (bus.s_ready) idx++;
         @(negedge clk);
         guard++;
      end
      check_int("midrst_words_fed", idx, WPR + 5);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_int("midrst_ctl", int'({bus.w_en, bus.s_ready, busy_o, done_o, err_o}), 0);
      check_int("midrst_addr", int'(bus.w_addr), 0);
      check_vec("midrst_wdata", bus.w_data, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vr = '{0, 2, 0, -1, 0, -1, 0, 2, 1};
      run_job(31, vr);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
